// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  localparam int unsigned STARVE_MAX_DEF = 4;

  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction fetch
// and data access; one transaction in flight, data priority with a fetch starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned ADDR_W     = 32,
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned STARVE_MAX = STARVE_MAX_DEF,
  localparam int unsigned BE_W       = be_width(DATA_W),
  localparam int unsigned CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [BE_W-1:0]   d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_we,
  output logic [BE_W-1:0]   m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_e       state, state_n;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_n;
  logic             flushed, flushed_n;
  logic             decide, grant_d, grant_i, starved;

  assign starved = if_req && (starve_cnt == CNT_W'(STARVE_MAX));

  // Next-state, grant and starvation/flush bookkeeping
  always_comb begin
    state_n      = state;
    starve_cnt_n = starve_cnt;
    flushed_n    = 1'b0;
    grant_d      = 1'b0;
    grant_i      = 1'b0;
    decide       = (state == IDLE) || m_ack;

    if (state == BUSY_I && !m_ack) begin
      flushed_n = flushed || if_flush;
    end

    if (decide) begin
      if (d_req && !starved) begin
        grant_d = 1'b1;
        state_n = BUSY_D;
      end else if (if_req) begin
        grant_i = 1'b1;
        state_n = BUSY_I;
      end else begin
        state_n = IDLE;
      end

      if (grant_d && if_req) begin
        starve_cnt_n = (starve_cnt == CNT_W'(STARVE_MAX)) ? starve_cnt
                                                          : starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt_n = '0;
      end
    end
  end

  // Completion and stall signals are same-cycle with m_ack
  assign if_valid = (state == BUSY_I) && m_ack && !flushed && !if_flush;
  assign d_valid  = (state == BUSY_D) && m_ack;
  assign if_rdata = m_rdata;
  assign d_rdata  = m_rdata;
  assign if_stall = if_req && !if_valid;
  assign d_stall  = d_req && !d_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      flushed    <= 1'b0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_cnt_n;
      flushed    <= flushed_n;
    end
  end

  // Memory request registers load only at a grant decision, so they hold through the wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_be    <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (decide) begin
      m_req <= grant_d || grant_i;
      if (grant_d) begin
        m_we    <= d_we;
        m_be    <= d_be;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (grant_i) begin
        m_we   <= 1'b0;
        m_be   <= '0;
        m_addr <= if_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = DW / 8;
  localparam int          SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, if_valid, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_valid, d_stall;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_req, m_we, m_ack;
  logic [BW-1:0] m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; if_flush = 0;
    d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    m_ack = 0; m_rdata = '0;
  endtask

  // Leaves the bench at a falling edge with reset released and inputs idle
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    if_req = 1;
    #1;
    n_checks += 4;
    if (m_req !== 1'b0) begin n_fail++; $display("FAIL reset_m_req got %0b want 0", m_req); end
    if ({m_we, m_be, m_addr, m_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_m_fields got we=%0b be=%h addr=%h wdata=%h want 0", m_we, m_be, m_addr, m_wdata);
    end
    if ({if_valid, d_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_valids got %b want 00", {if_valid, d_valid}); end
    if (if_stall !== 1'b1) begin n_fail++; $display("FAIL reset_if_stall got %0b want 1", if_stall); end
    @(negedge clk);
    rst = 0;
    if_req = 0;
  endtask

  task automatic test_single_fetch();
    do_reset();
    if_req = 1; if_addr = 32'h0000_0004;
    #1;
    n_checks += 2;
    if (if_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c0 got %0b want 1", if_stall); end
    if (m_req !== 1'b0) begin n_fail++; $display("FAIL fetch_mreq_c0 got %0b want 0", m_req); end
    @(negedge clk);
    m_ack = 1; m_rdata = 32'h2008_0001; if_req = 0;
    #1;
    n_checks += 5;
    if (m_req !== 1'b1) begin n_fail++; $display("FAIL fetch_mreq_c1 got %0b want 1", m_req); end
    if (m_addr !== 32'h0000_0004) begin n_fail++; $display("FAIL fetch_addr got %h want 00000004", m_addr); end
    if (m_we !== 1'b0 || m_be !== '0) begin n_fail++; $display("FAIL fetch_we_be got %0b/%h want 0/0", m_we, m_be); end
    if (if_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid got %0b want 1", if_valid); end
    if (if_rdata !== 32'h2008_0001) begin n_fail++; $display("FAIL fetch_rdata got %h want 20080001", if_rdata); end
    @(negedge clk);
    m_ack = 0;
    #1;
    n_checks += 2;
    if (m_req !== 1'b0) begin n_fail++; $display("FAIL fetch_mreq_after got %0b want 0", m_req); end
    if (if_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_valid_after got %0b want 0", if_valid); end
  endtask

  task automatic test_priority();
    do_reset();
    if_req = 1; if_addr = 32'h40;
    d_req = 1; d_we = 1; d_addr = 32'h100; d_be = 4'b0011; d_wdata = 32'hABCD;
    @(negedge clk);
    m_ack = 1; m_rdata = 32'h1111_2222; d_req = 0;
    #1;
    n_checks += 4;
    if ({m_req, m_we} !== 2'b11) begin n_fail++; $display("FAIL prio_data_req_we got %b want 11", {m_req, m_we}); end
    if (m_be !== 4'b0011 || m_addr !== 32'h100 || m_wdata !== 32'hABCD) begin
      n_fail++; $display("FAIL prio_data_fields got be=%b addr=%h wdata=%h want 0011/100/abcd", m_be, m_addr, m_wdata);
    end
    if (d_valid !== 1'b1) begin n_fail++; $display("FAIL prio_d_valid got %0b want 1", d_valid); end
    if (if_stall !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("FAIL prio_if_wait got stall=%0b valid=%0b want 1/0", if_stall, if_valid); end
    @(negedge clk);
    if_req = 0; m_rdata = 32'h3333_4444;
    #1;
    n_checks += 3;
    if (m_req !== 1'b1) begin n_fail++; $display("FAIL prio_no_bubble got m_req=%0b want 1", m_req); end
    if (m_we !== 1'b0 || m_be !== '0 || m_addr !== 32'h40) begin
      n_fail++; $display("FAIL prio_fetch_fields got we=%0b be=%b addr=%h want 0/0000/40", m_we, m_be, m_addr);
    end
    if (if_valid !== 1'b1 || if_rdata !== 32'h3333_4444) begin
      n_fail++; $display("FAIL prio_fetch_valid got %0b/%h want 1/33334444", if_valid, if_rdata);
    end
    @(negedge clk);
    m_ack = 0;
  endtask

  task automatic test_starvation();
    logic [AW-1:0] want;
    do_reset();
    if_req = 1; if_addr = 32'h40;
    d_req = 1; d_we = 0; d_addr = 32'h200;
    for (int k = 0; k < 2 * (SMAX + 1); k++) begin
      @(negedge clk);
      m_ack = 1; m_rdata = DW'(k);
      #1;
      // SMAX data grants, then one fetch grant, repeating
      want = ((k % (SMAX + 1)) == SMAX) ? 32'h40 : 32'h200;
      n_checks += 2;
      if (m_req !== 1'b1 || m_addr !== want) begin
        n_fail++; $display("FAIL starve_grant%0d got req=%0b addr=%h want 1/%h", k, m_req, m_addr, want);
      end
      if ({if_valid, d_valid} !== ((want == 32'h40) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL starve_valid%0d got %b", k, {if_valid, d_valid});
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    if_req = 1; if_addr = 32'h80;
    @(negedge clk);
    if_flush = 1; if_addr = 32'h90;
    #1;
    n_checks += 1;
    if (if_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_c1 got %0b want 0", if_valid); end
    @(negedge clk);
    if_flush = 0;
    @(negedge clk);
    #1;
    n_checks += 1;
    if (m_req !== 1'b1 || m_addr !== 32'h80) begin n_fail++; $display("FAIL flush_hold got req=%0b addr=%h want 1/80", m_req, m_addr); end
    @(negedge clk);
    m_ack = 1; m_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks += 2;
    if (if_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got if_valid=%0b want 0", if_valid); end
    if (if_stall !== 1'b1) begin n_fail++; $display("FAIL flush_stall got %0b want 1", if_stall); end
    @(negedge clk);
    if_req = 0; m_rdata = 32'h0BAD_CAFE;
    #1;
    n_checks += 2;
    if (m_req !== 1'b1 || m_addr !== 32'h90) begin n_fail++; $display("FAIL flush_regrant got req=%0b addr=%h want 1/90", m_req, m_addr); end
    if (if_valid !== 1'b1) begin n_fail++; $display("FAIL flush_next_valid got %0b want 1", if_valid); end
    @(negedge clk);
    m_ack = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    d_req = 1; d_addr = 32'h300;
    @(negedge clk);
    #1;
    n_checks += 1;
    if (m_req !== 1'b1) begin n_fail++; $display("FAIL arst_pre got m_req=%0b want 1", m_req); end
    rst = 1; d_req = 0;
    #1;
    n_checks += 2;
    if (m_req !== 1'b0 || m_addr !== '0) begin n_fail++; $display("FAIL arst_immediate got req=%0b addr=%h want 0/0", m_req, m_addr); end
    if (d_stall !== 1'b0 || d_valid !== 1'b0) begin n_fail++; $display("FAIL arst_d got stall=%0b valid=%0b want 0/0", d_stall, d_valid); end
    @(negedge clk);
    rst = 0; m_ack = 1; m_rdata = 32'h1234_5678;
    #1;
    n_checks += 1;
    if ({if_valid, d_valid, m_req} !== 3'b000) begin n_fail++; $display("FAIL arst_late_ack got %b want 000", {if_valid, d_valid, m_req}); end
    @(negedge clk);
    m_ack = 0;
    #1;
    n_checks += 1;
    if (m_req !== 1'b0) begin n_fail++; $display("FAIL arst_after got m_req=%0b want 0", m_req); end
  endtask

  // lat > 0: fixed latency with loads only; lat == 0: random ack timing and writes
  task automatic test_random(input int n, input int lat);
    int            owner, starve, wait_c, win;
    bit            flushed, mreq, mwe, ack, fl, vi, vd;
    logic [BW-1:0] mbe;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata, rd;
    bit            ip, dp, dwe;
    logic [AW-1:0] ia, da;
    logic [BW-1:0] dbe;
    logic [DW-1:0] dwd;
    do_reset();
    owner = 0; starve = 0; wait_c = 0; flushed = 0;
    mreq = 0; mwe = 0; mbe = '0; maddr = '0; mwdata = '0;
    ip = 0; dp = 0; dwe = 0; ia = '0; da = '0; dbe = '0; dwd = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      ack = (lat > 0) ? (owner != 0 && wait_c == lat - 1) : ($urandom_range(0, 2) == 0);
      fl  = (owner == 1) && ($urandom_range(0, 9) == 0);
      rd  = $urandom;
      vi  = (owner == 1) && ack && !flushed && !fl;
      vd  = (owner == 2) && ack;
      if (fl) ia = {$urandom_range(0, 255), 2'b00};
      if (vi) ip = 0;
      if (vd) dp = 0;
      if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; ia = {$urandom_range(0, 255), 2'b00}; end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1; da = 32'h1000 + {$urandom_range(0, 255), 2'b00};
        dwe = (lat > 0) ? 1'b0 : 1'($urandom_range(0, 1));
        dbe = BW'($urandom_range(1, 15)); dwd = $urandom;
      end
      if_req = ip; if_addr = ia; if_flush = fl;
      d_req = dp; d_we = dwe; d_be = dbe; d_addr = da; d_wdata = dwd;
      m_ack = ack; m_rdata = rd;
      #1;
      n_checks += 5;
      if (if_valid !== vi) begin n_fail++; $display("FAIL rnd%0d_if_valid got %0b want %0b", c, if_valid, vi); end
      if (d_valid !== vd) begin n_fail++; $display("FAIL rnd%0d_d_valid got %0b want %0b", c, d_valid, vd); end
      if (if_stall !== (ip && !vi)) begin n_fail++; $display("FAIL rnd%0d_if_stall got %0b want %0b", c, if_stall, ip && !vi); end
      if (d_stall !== (dp && !vd)) begin n_fail++; $display("FAIL rnd%0d_d_stall got %0b want %0b", c, d_stall, dp && !vd); end
      if (m_req !== mreq) begin n_fail++; $display("FAIL rnd%0d_m_req got %0b want %0b", c, m_req, mreq); end
      if (mreq) begin
        n_checks++;
        if (m_we !== mwe || m_be !== mbe || m_addr !== maddr) begin
          n_fail++; $display("FAIL rnd%0d_m_fields got %0b/%h/%h want %0b/%h/%h", c, m_we, m_be, m_addr, mwe, mbe, maddr);
        end
      end
      if (owner == 2) begin
        n_checks++;
        if (m_wdata !== mwdata) begin n_fail++; $display("FAIL rnd%0d_m_wdata got %h want %h", c, m_wdata, mwdata); end
      end
      if (vi || vd) begin
        n_checks++;
        if ((vi ? if_rdata : d_rdata) !== rd) begin n_fail++; $display("FAIL rnd%0d_rdata got %h want %h", c, vi ? if_rdata : d_rdata, rd); end
      end
      // Reference model: one outstanding transaction, data first unless fetch has waited SMAX grants
      if (owner == 1) flushed = ack ? 1'b0 : (flushed || fl);
      if (owner == 0 || ack) begin
        win = (dp && !(ip && starve == SMAX)) ? 2 : (ip ? 1 : 0);
        starve = (win == 2 && ip) ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
        mreq = (win != 0);
        if (win == 2) begin mwe = dwe; mbe = dbe; maddr = da; mwdata = dwd; end
        if (win == 1) begin mwe = 0; mbe = '0; maddr = ia; end
        owner = win;
        wait_c = 0;
      end else begin
        wait_c++;
      end
      @(posedge clk);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_flush();
    test_async_reset();
    test_random(300, 5);
    test_random(1500, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, variable-latency memory between the instruction-fetch stage and the data-memory stage of the pipelined CPU. Holds one transaction outstanding at a time, grants data accesses priority with a bounded starvation guard for fetch, and generates the per-stage stall signals that freeze the PC register and the MEM-stage registers while an access is pending.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- STARVE_MAX, 4, consecutive data grants allowed while if_req waits (>=1)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch read request; address held stable until if_valid
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  branch redirect; discard in-flight fetch result
- if_rdata  out  DATA_W  fetch data, valid with if_valid
- if_valid  out  1  fetch complete this cycle
- if_stall  out  1  fetch stage must hold (drives IF stall)
- d_req  in  1  data request; all d_* held stable until d_valid
- d_we  in  1  1 = write
- d_be  in  DATA_W/8  write byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data, valid with d_valid
- d_valid  out  1  data access complete this cycle
- d_stall  out  1  MEM stage must hold
- m_req  out  1  memory request, registered
- m_we, m_be, m_addr, m_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  registered request fields
- m_ack  in  1  memory completes current request (read data valid)
- m_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. Reset: IDLE, m_req=0, m_we=0, m_be=0, m_addr=0, m_wdata=0, starve_cnt=0, flushed=0.
- Grant decision (made in IDLE, or in BUSY_x on the m_ack cycle): d_req && !(if_req && starve_cnt==STARVE_MAX) -> BUSY_D; else if_req -> BUSY_I; else IDLE.
- starve_cnt: +1 on each data grant while if_req high, saturates at STARVE_MAX; cleared on any fetch grant or when if_req low at a grant decision.
- On a grant, m_* registers load the winner's fields next edge; fetch grants force m_we=0, m_be=0. m_req stays 1 and fields stay constant until the m_ack cycle.
- if_valid = BUSY_I && m_ack && !flushed && !if_flush; if_rdata = m_rdata (pass-through). d_valid = BUSY_D && m_ack; d_rdata = m_rdata.
- if_stall = if_req && !if_valid; d_stall = d_req && !d_valid.
- if_flush during BUSY_I: sets flushed; transaction runs to m_ack (no abort), result dropped; flushed clears on leaving BUSY_I. if_flush in IDLE/BUSY_D: no effect.
- m_ack in IDLE ignored. Requests dropped mid-transaction: transaction still completes; valid still pulses.

## Timing
- Minimum latency: request at cycle 0 (IDLE) -> m_req cycle 1 -> m_ack cycle 1 -> *_valid cycle 1. Two-cycle access.
- Back-to-back: on m_ack cycle the next grant loads, so m_req remains high with new fields on the following cycle; zero idle bubbles.
- Simultaneous fresh if_req and d_req in IDLE: data wins unless starve_cnt==STARVE_MAX.
- Async rst mid-transaction: m_req falls immediately, state IDLE; pending memory response after reset is ignored.

## Structure
- Package mem_arb_pkg: state enum (IDLE, BUSY_I, BUSY_D), BE_W = DATA_W/8 derivation helper, default STARVE_MAX.
- Single module; starvation counter inline (no sub-module warranted).

## Test plan
- Single fetch, if_addr=0x0000_0004, m_ack one cycle after m_req with m_rdata=0x2008_0001 -> if_valid 1 cycle, if_rdata=0x2008_0001, if_stall high exactly until that cycle.
- Simultaneous if_req and d_req write (d_addr=0x100, d_be=4'b0011, d_wdata=0xABCD) -> data granted first, m_we=1, m_be=0011; fetch granted on the following cycle with no bubble.
- d_req held continuously with if_req high, STARVE_MAX=4 -> exactly 4 data grants, then one fetch grant, then data resumes.
- if_flush pulsed while BUSY_I, m_ack 3 cycles later -> no if_valid, m_req held until ack, then next grant.
- rst asserted between grant and m_ack -> m_req=0 same cycle, all outputs at reset values, late m_ack produces no valid.
- Memory with 5-cycle latency, alternating fetch/load -> m_* fields stable during every wait, each valid pulse matches its request.
